// File: rtl/uesprit_acc_ctrl_if.sv
// Result-frame handshake between the accumulation controller and its consumer.
// The master holds the frame and raises res_valid; the slave answers with res_ready.
interface uesprit_acc_ctrl_if #(
    parameter int DOUT_WIDTH = 32
);
    logic [DOUT_WIDTH-1:0] res_r11;
    logic [DOUT_WIDTH-1:0] res_r22;
    logic [DOUT_WIDTH-1:0] res_r12_re;
    logic [DOUT_WIDTH-1:0] res_r12_im;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output res_r11, res_r22, res_r12_re, res_r12_im, res_valid,
        input  res_ready
    );

    modport slave (
        input  res_r11, res_r22, res_r12_re, res_r12_im, res_valid,
        output res_ready
    );
endinterface

// File: rtl/uesprit_acc_ctrl.sv
// U-ESPRIT accumulation scheduler: paces new_acc, drops the stale first frame,
// and buffers each finished correlator frame behind a valid/ready handshake.
module uesprit_acc_ctrl #(
    parameter int DOUT_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [LEN_WIDTH-1:0]  cfg_acc_len,
    input  logic                  din_valid,
    output logic                  new_acc,
    input  logic [DOUT_WIDTH-1:0] acc_r11,
    input  logic [DOUT_WIDTH-1:0] acc_r22,
    input  logic [DOUT_WIDTH-1:0] acc_r12_re,
    input  logic [DOUT_WIDTH-1:0] acc_r12_im,
    input  logic                  acc_valid,
    uesprit_acc_ctrl_if.master    res,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [LEN_WIDTH-1:0]  len_m1_q;
    logic                  discard_q;
    logic [DOUT_WIDTH-1:0] r11_q;
    logic [DOUT_WIDTH-1:0] r22_q;
    logic [DOUT_WIDTH-1:0] r12_re_q;
    logic [DOUT_WIDTH-1:0] r12_im_q;
    logic                  rv_q;
    logic                  ovf_q;
    logic [CNT_WIDTH-1:0]  fcnt_q;

    logic                  last;
    logic                  live;
    logic                  cap;
    logic                  drop;

    assign last    = (cnt_q == len_m1_q);
    assign new_acc = din_valid &
                     ((state_q == PRIME) | ((state_q == RUN) & last));

    // Frames that survive the stale-frame discard and arrive while running
    assign live = acc_valid & ~discard_q & (state_q != IDLE);
    assign cap  = live & (~rv_q | res.res_ready);
    assign drop = live & rv_q & ~res.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_m1_q  <= '0;
            discard_q <= 1'b0;
            r11_q     <= '0;
            r22_q     <= '0;
            r12_re_q  <= '0;
            r12_im_q  <= '0;
            rv_q      <= 1'b0;
            ovf_q     <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            rv_q  <= cap | (rv_q & ~res.res_ready);
            ovf_q <= drop | (ovf_q & ~ovf_clr);
            if (cap) begin
                r11_q    <= acc_r11;
                r22_q    <= acc_r22;
                r12_re_q <= acc_r12_re;
                r12_im_q <= acc_r12_im;
                fcnt_q   <= fcnt_q + CNT_WIDTH'(1);
            end

            // A fresh prime re-arms discard even if a stale frame lands now
            if ((state_q == PRIME) && din_valid)
                discard_q <= 1'b1;
            else if (acc_valid && discard_q)
                discard_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (cfg_en) begin
                        len_m1_q <= (cfg_acc_len == '0) ? '0
                                  : cfg_acc_len - LEN_WIDTH'(1);
                        state_q  <= PRIME;
                    end
                end
                PRIME: begin
                    cnt_q <= '0;
                    if (!cfg_en)
                        state_q <= IDLE;
                    else if (din_valid)
                        state_q <= RUN;
                end
                RUN: begin
                    if (!cfg_en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (din_valid) begin
                        cnt_q <= last ? '0 : cnt_q + LEN_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign res.res_r11    = r11_q;
    assign res.res_r22    = r22_q;
    assign res.res_r12_re = r12_re_q;
    assign res.res_r12_im = r12_im_q;
    assign res.res_valid  = rv_q;
    assign ovf            = ovf_q;
    assign frame_cnt      = fcnt_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uesprit_acc_ctrl.sv
// Directed bench for uesprit_acc_ctrl: a cycle table plus
// hand-written gap, back-to-back and reset sequences.
module tb_uesprit_acc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [15:0] cfg_acc_len;
    logic        din_valid;
    logic        new_acc;
    logic [31:0] acc_r11, acc_r22, acc_r12_re, acc_r12_im;
    logic        acc_valid;
    logic        ovf;
    logic        ovf_clr;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_chk;
    int n_fail;

    uesprit_acc_ctrl_if #(.DOUT_WIDTH(32)) rif ();

    assign acc_r22    = acc_r11 ^ 32'h0000_1000;
    assign acc_r12_re = acc_r11 ^ 32'h0000_2000;
    assign acc_r12_im = acc_r11 ^ 32'h0000_4000;

    uesprit_acc_ctrl #(
        .DOUT_WIDTH(32),
        .LEN_WIDTH (16),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .cfg_acc_len(cfg_acc_len),
        .din_valid  (din_valid),
        .new_acc    (new_acc),
        .acc_r11    (acc_r11),
        .acc_r22    (acc_r22),
        .acc_r12_re (acc_r12_re),
        .acc_r12_im (acc_r12_im),
        .acc_valid  (acc_valid),
        .res        (rif.master),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] len;
        logic        dv;
        logic        av;
        logic [31:0] d;
        logic        rdy;
        logic        clr;
        logic        e_na;
        logic        e_bsy;
        logic        e_rv;
        logic [31:0] e_r11;
        logic        e_ovf;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic en, logic [15:0] len, logic dv, logic av, logic [31:0] d,
        logic rdy, logic clr, logic na, logic bsy, logic rv,
        logic [31:0] r11, logic ov, logic [15:0] fc);
        vec_t v;
        v.en = en; v.len = len; v.dv = dv; v.av = av; v.d = d;
        v.rdy = rdy; v.clr = clr; v.e_na = na; v.e_bsy = bsy;
        v.e_rv = rv; v.e_r11 = r11; v.e_ovf = ov; v.e_fc = fc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(logic en, logic [15:0] len, logic dv, logic av,
                         logic [31:0] d, logic rdy, logic clr);
        cfg_en        = en;
        cfg_acc_len   = len;
        din_valid     = dv;
        acc_valid     = av;
        acc_r11       = d;
        rif.res_ready = rdy;
        ovf_clr       = clr;
    endtask

    initial begin
        int fc;
        int k;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(0, 16'd4, 0, 0, 32'h0, 1, 0);

        //  en len dv av data      rdy clr na bsy rv r11     ovf fc
        tbl.push_back(mk(0, 4, 0, 0, 32'h00, 1, 0, 0, 0, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 0, 0, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 1, 1, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 1, 32'h11, 1, 0, 0, 1, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 0, 1, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 1, 1, 0, 32'h00, 0, 0));
        tbl.push_back(mk(1, 4, 1, 1, 32'hA1, 1, 0, 0, 1, 1, 32'hA1, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 0, 1, 0, 32'hA1, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 0, 1, 0, 32'hA1, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 1, 0, 1, 1, 0, 32'hA1, 0, 1));
        tbl.push_back(mk(1, 4, 1, 1, 32'hA2, 1, 0, 0, 1, 1, 32'hA2, 0, 2));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 0, 0, 0, 1, 1, 32'hA2, 0, 2));
        tbl.push_back(mk(1, 4, 1, 1, 32'hB1, 0, 0, 0, 1, 1, 32'hA2, 1, 2));
        tbl.push_back(mk(1, 4, 1, 0, 32'h00, 0, 1, 1, 1, 1, 32'hA2, 0, 2));
        tbl.push_back(mk(1, 4, 1, 1, 32'hB2, 1, 0, 0, 1, 1, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 4, 1, 1, 32'hC1, 0, 1, 0, 1, 1, 32'hB2, 1, 3));
        tbl.push_back(mk(0, 4, 1, 0, 32'h00, 1, 1, 0, 1, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(0, 4, 1, 1, 32'hD1, 1, 0, 0, 0, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 0, 0, 32'h00, 1, 0, 0, 0, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 0, 0, 32'h00, 1, 0, 0, 1, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 1, 0, 32'h00, 1, 0, 1, 1, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 0, 1, 32'hE0, 1, 0, 0, 1, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 1, 0, 32'h00, 1, 0, 0, 1, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 0, 0, 32'h00, 1, 0, 0, 1, 0, 32'hB2, 0, 3));
        tbl.push_back(mk(1, 2, 1, 1, 32'hE1, 1, 0, 1, 1, 1, 32'hE1, 0, 4));
        tbl.push_back(mk(1, 2, 1, 0, 32'h00, 1, 0, 0, 1, 0, 32'hE1, 0, 4));
        tbl.push_back(mk(1, 2, 1, 0, 32'h00, 1, 0, 1, 1, 0, 32'hE1, 0, 4));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", rif.res_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_r11", rif.res_r11, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].en, tbl[i].len, tbl[i].dv, tbl[i].av,
                  tbl[i].d, tbl[i].rdy, tbl[i].clr);
            #1;
            chk($sformatf("v%0d_new_acc", i), new_acc, tbl[i].e_na);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_bsy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_res_valid", i), rif.res_valid, tbl[i].e_rv);
            chk($sformatf("v%0d_res_r11", i), rif.res_r11, tbl[i].e_r11);
            chk($sformatf("v%0d_ovf", i), ovf, tbl[i].e_ovf);
            chk($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].e_fc);
        end
        fc = 4;

        // L=3 with din_valid toggling: new_acc on every third valid sample
        @(negedge clk);
        drive(0, 3, 0, 0, 0, 1, 0);
        @(negedge clk);
        drive(1, 3, 0, 0, 0, 1, 0);
        #1;
        chk("l3_idle_new_acc", new_acc, 0);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1, 3, (i % 2) == 0, 0, 0, 1, 0);
            #1;
            chk($sformatf("l3_new_acc_%0d", i), new_acc,
                ((i % 2) == 0) && ((k % 3) == 0));
            if ((i % 2) == 0) k++;
        end
        @(posedge clk);
        #1;
        chk("l3_frame_cnt", frame_cnt, fc);

        // L=0 acts as L=1: back-to-back frames, no drops
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 1, 0);
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 1, 0);
        #1;
        chk("l1_idle_new_acc", new_acc, 0);
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 1, 0);
        #1;
        chk("l1_prime_new_acc", new_acc, 1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            drive(1, 0, 1, 1, 32'hF0 + j, 1, 0);
            #1;
            chk($sformatf("l1_new_acc_%0d", j), new_acc, 1);
            @(posedge clk);
            #1;
            if (j > 0) fc++;
            chk($sformatf("l1_frame_cnt_%0d", j), frame_cnt, fc);
            chk($sformatf("l1_res_valid_%0d", j), rif.res_valid, j > 0);
            chk($sformatf("l1_ovf_%0d", j), ovf, 0);
        end
        chk("l1_res_r11", rif.res_r11, 32'hF7);
        chk("l1_res_r22", rif.res_r22, 32'hF7 ^ 32'h1000);
        chk("l1_res_r12_re", rif.res_r12_re, 32'hF7 ^ 32'h2000);
        chk("l1_res_r12_im", rif.res_r12_im, 32'hF7 ^ 32'h4000);

        // Asynchronous reset while running with a held frame and ovf set
        @(negedge clk);
        drive(1, 0, 1, 1, 32'hAA, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_ovf", ovf, 1);
        chk("pre_rst_res_valid", rif.res_valid, 1);
        chk("pre_rst_res_r11", rif.res_r11, 32'hF7);
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res_valid", rif.res_valid, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_new_acc", new_acc, 0);
        chk("arst_res_r11", rif.res_r11, 0);
        chk("arst_res_r12_im", rif.res_r12_im, 0);
        @(negedge clk);
        drive(0, 1, 1, 0, 0, 1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1, 1, 0, 0, 1, 0);
            #1;
            chk($sformatf("post_rst_busy_%0d", i), busy, 0);
            chk($sformatf("post_rst_new_acc_%0d", i), new_acc, 0);
        end
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 1, 0);
        #1;
        chk("reen_idle_new_acc", new_acc, 0);
        @(negedge clk);
        #1;
        chk("reen_prime_new_acc", new_acc, 1);
        chk("reen_prime_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
